// File: rtl/mem_split_ctrl_pkg.sv
// ============================================================================
// Module      : mem_split_ctrl_pkg
// Description : Shared types and lane-mask helpers for the memory-port splitter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_split_ctrl_pkg;

    localparam logic [4:0] C_OP_WORD_LO = 5'd3;
    localparam logic [4:0] C_OP_WORD_HI = 5'd5;
    localparam logic [4:0] C_OP_HALF_LO = 5'd6;
    localparam logic [4:0] C_OP_HALF_HI = 5'd8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Anything outside the word/half ranges is treated as a byte access,
    // which can never cross a word boundary.
    function automatic size_e size_of(input logic [4:0] opcode);
        if (opcode >= C_OP_WORD_LO && opcode <= C_OP_WORD_HI)
            return SZ_WORD;
        else if (opcode >= C_OP_HALF_LO && opcode <= C_OP_HALF_HI)
            return SZ_HALF;
        else
            return SZ_BYTE;
    endfunction

    function automatic logic [3:0] lane_mask(input size_e size);
        case (size)
            SZ_WORD: return 4'b1111;
            SZ_HALF: return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic needs_split(input size_e size, input logic [1:0] offset);
        return ((size == SZ_WORD) && (offset != 2'd0)) ||
               ((size == SZ_HALF) && (offset == 2'd3));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_split_ctrl_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-lane write mask and store-data shift for either half
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_split_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        second_i,
    input  logic [31:0] data_i,
    output logic [3:0]  wen_mask_o,
    output logic [31:0] wdata_o
);

    size_e      w_size;
    logic [3:0] w_base_mask;
    logic [2:0] w_back_shift;

    assign w_size       = size_e'(size_i);
    assign w_base_mask  = lane_mask(w_size);
    // Second half carries the bytes that spilled past lane 3 of the first word.
    assign w_back_shift = 3'd4 - {1'b0, offset_i};

    always_comb begin
        if (!second_i) begin
            wen_mask_o = w_base_mask << offset_i;
            wdata_o    = data_i << {offset_i, 3'b000};
        end else begin
            wen_mask_o = w_base_mask >> w_back_shift;
            wdata_o    = data_i >> {w_back_shift, 3'b000};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_split_ctrl.sv
// ============================================================================
// Module      : mem_split_ctrl
// Description : Data-memory port sequencer; splits boundary-crossing accesses
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_split_ctrl
    import mem_split_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             halt,
    input  logic             req_valid,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [4:0]       opcode,
    input  logic [31:0]      addr,
    input  logic [31:0]      store_data,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             mem_ren,
    output logic [3:0]       mem_wen,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             stall,
    output logic             misaligned,
    output logic [CNT_W-1:0] split_count
);

    state_e            state_q, state_d;
    logic              load_q, store_q;
    size_e             size_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [CNT_W-1:0]  count_q;
    logic              latch_en;

    logic              w_active;
    logic              w_in_second;
    size_e             w_in_size;
    logic              w_split;
    logic [31:0]       w_base;
    size_e             w_al_size;
    logic [1:0]        w_al_offset;
    logic [31:0]       w_al_data;
    logic [3:0]        w_al_mask;
    logic [31:0]       w_al_wdata;

    assign w_active    = clk_en && !halt && !rst;
    assign w_in_second = (state_q == ST_SECOND);
    assign w_in_size   = size_of(opcode);
    assign w_split     = needs_split(w_in_size, addr[1:0]);
    assign w_base      = {addr[31:2], 2'b00};

    // In SECOND the aligner sees only the latched request, never live inputs.
    assign w_al_size   = w_in_second ? size_q       : w_in_size;
    assign w_al_offset = w_in_second ? addr_q[1:0]  : addr[1:0];
    assign w_al_data   = w_in_second ? data_q       : store_data;

    mem_lane_align u_align (
        .size_i     (w_al_size),
        .offset_i   (w_al_offset),
        .second_i   (w_in_second),
        .data_i     (w_al_data),
        .wen_mask_o (w_al_mask),
        .wdata_o    (w_al_wdata)
    );

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_active && req_valid && (is_load || is_store) && !flush) begin
                    mem_addr  = w_base;
                    mem_ren   = is_load;
                    mem_wen   = is_load ? 4'b0000 : w_al_mask;
                    mem_wdata = is_load ? 32'h0   : w_al_wdata;
                    if (w_split) begin
                        stall = 1'b1;
                        if (mem_ready) begin
                            latch_en = 1'b1;
                            state_d  = ST_SECOND;
                        end
                    end else begin
                        stall = !mem_ready;
                    end
                end
            end
            ST_SECOND: begin
                if (w_active) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        mem_addr   = {addr_q[31:2], 2'b00} + 32'd4;
                        mem_ren    = load_q;
                        mem_wen    = load_q ? 4'b0000 : w_al_mask;
                        mem_wdata  = load_q ? 32'h0   : w_al_wdata;
                        misaligned = load_q;
                        stall      = !mem_ready;
                        if (mem_ready)
                            state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                load_q  <= is_load;
                store_q <= is_store && !is_load;
                size_q  <= w_in_size;
                addr_q  <= addr;
                data_q  <= store_data;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign split_count = count_q;

endmodule

`default_nettype wire
